// File: rtl/ucdp_sfifo_rdburst_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and its reset value.
package ucdp_sfifo_rdburst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam state_t state_idle_p = IDLE;

endpackage

// File: rtl/ucdp_rdburst_tmo.sv
// Idle timeout counter: counts partial-fill cycles, saturates, and flags when
// the next count would reach the live timeout value. A zero timeout disables it.
module ucdp_rdburst_tmo #(
  parameter int twidth_p = 8
) (
  input  logic                src_clk_i,
  input  logic                src_rst_i,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [twidth_p-1:0] tmo_i,
  output logic                hit_o
);

  logic [twidth_p-1:0] tmo_cnt;
  logic [twidth_p:0]   cnt_nxt;

  // One extra bit so the saturated value never aliases onto a small timeout.
  assign cnt_nxt = {1'b0, tmo_cnt} + {{twidth_p{1'b0}}, 1'b1};
  assign hit_o   = (tmo_i != '0) && (cnt_nxt == {1'b0, tmo_i});

  // Saturating counter, cleared on request or while the timeout is disabled.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i || clr_i || (tmo_i == '0)) begin
      tmo_cnt <= '0;
    end else if (inc_i && (tmo_cnt != '1)) begin
      tmo_cnt <= cnt_nxt[twidth_p-1:0];
    end
  end

endmodule

// File: rtl/ucdp_sfifo_rdburst.sv
// Burst reader for a synchronous FIFO read port. Pops bursts of burst_p words
// once enough are stored, flushes partial fills after a timeout, and presents
// the words on a registered stream with a last-of-burst marker.
//
// Stream handshake: a word transfers on a cycle where out_valid_o and
// out_ready_i are both high; once raised, out_valid_o, out_data_o and
// out_last_o stay stable until that transfer. A transfer and a new pop in the
// same cycle replace the word without a bubble.
module ucdp_sfifo_rdburst
  import ucdp_sfifo_rdburst_pkg::*;
#(
  parameter int dwidth_p = 8,
  parameter int depth_p  = 4,
  parameter int awidth_p = $clog2(depth_p + 1),
  parameter int burst_p  = 4,
  parameter int twidth_p = 8
) (
  input  logic                src_clk_i,
  input  logic                src_rst_i,
  output logic                rd_en_o,
  input  logic [dwidth_p-1:0] rd_data_i,
  input  logic                rd_empty_i,
  input  logic [awidth_p-1:0] rd_data_avail_i,
  input  logic [twidth_p-1:0] tmo_i,
  output logic                out_valid_o,
  output logic [dwidth_p-1:0] out_data_o,
  output logic                out_last_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output state_t              state_o
);

  localparam logic [awidth_p-1:0] burst_c = awidth_p'(burst_p);
  localparam logic [awidth_p-1:0] one_c   = awidth_p'(1);

  state_t              state;
  logic [awidth_p-1:0] cnt;
  logic                in_idle;
  logic                level_full;
  logic                level_part;
  logic                tmo_hit;
  logic                tmo_flush;
  logic                pop;

  assign in_idle    = (state == IDLE);
  assign level_full = (rd_data_avail_i >= burst_c);
  assign level_part = (rd_data_avail_i != '0) && !level_full;
  assign tmo_flush  = in_idle && level_part && tmo_hit;

  // Reset also blocks the pop so a reset leaves the FIFO contents untouched.
  assign pop     = !in_idle && !rd_empty_i && (!out_valid_o || out_ready_i) && !src_rst_i;
  assign rd_en_o = pop;
  assign busy_o  = !in_idle;
  assign state_o = state;

  ucdp_rdburst_tmo #(
    .twidth_p (twidth_p)
  ) u_tmo (
    .src_clk_i (src_clk_i),
    .src_rst_i (src_rst_i),
    .clr_i     (!in_idle || level_full || tmo_flush || (rd_data_avail_i == '0)),
    .inc_i     (in_idle && level_part),
    .tmo_i     (tmo_i),
    .hit_o     (tmo_hit)
  );

  // Burst FSM: a full level wins over timeout; the pop of the final word ends the burst.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      state <= state_idle_p;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (level_full) begin
            state <= BURST;
            cnt   <= burst_c;
          end else if (tmo_flush) begin
            state <= FLUSH;
            cnt   <= rd_data_avail_i;
          end
        end
        BURST, FLUSH: begin
          if (pop) begin
            cnt <= cnt - 1'b1;
            if (cnt == one_c) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output register: load on pop, drop valid on an accept without a refill.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (pop) begin
      out_valid_o <= 1'b1;
      out_data_o  <= rd_data_i;
      out_last_o  <= (cnt == one_c);
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
